// File: rtl/case_1_mul_pkg.sv
// Shared widths, pipeline stage records and a constant-width helper for the shared multiplier.
// Stage records carry a tag wide enough for up to 8 requesters.
package case_1_mul_pkg;

  localparam int DIN0_W    = 7;
  localparam int DIN1_W    = 7;
  localparam int DOUT_W    = 11;
  localparam int TAG_MAX_W = 3;

  typedef struct packed {
    logic [DIN0_W-1:0]    din0;
    logic [DIN1_W-1:0]    din1;
    logic [TAG_MAX_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [DOUT_W-1:0]    dout;
    logic                 ovf;
    logic [TAG_MAX_W-1:0] tag;
  } s2_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/case_1_mul_share_arb_if.sv
// Operand/result handshake bundle between N_REQ requesters and the shared multiplier.
// master = requester side, slave = multiplier side.
interface case_1_mul_share_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DIN0_W = 7,
  parameter int DIN1_W = 7,
  parameter int DOUT_W = 11
);
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ-1:0]        req_rdy;
  logic [N_REQ*DIN0_W-1:0] req_din0;
  logic [N_REQ*DIN1_W-1:0] req_din1;
  logic [N_REQ-1:0]        rsp_vld;
  logic [N_REQ-1:0]        rsp_rdy;
  logic [DOUT_W-1:0]       rsp_dout;
  logic                    rsp_ovf;
  logic                    busy;

  modport master (
    output req_vld, req_din0, req_din1, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_dout, rsp_ovf, busy
  );

  modport slave (
    input  req_vld, req_din0, req_din1, rsp_rdy,
    output req_rdy, rsp_vld, rsp_dout, rsp_ovf, busy
  );
endinterface

// File: rtl/case_1_mul_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping; purely combinational.
// Latency 0; no backpressure of its own.
module case_1_mul_rr_pick
  import case_1_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [TAG_W-1:0] gnt_idx,
  output logic             any
);

  logic [TAG_W:0] pos;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (TAG_W + 1)'(k);
      if (pos >= (TAG_W + 1)'(N_REQ)) pos = pos - (TAG_W + 1)'(N_REQ);
      if (req[pos[TAG_W-1:0]]) begin
        gnt_idx = pos[TAG_W-1:0];
        any     = 1'b1;
      end
    end
    gnt_oh = any ? (N_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/case_1_mul_share_arb.sv
// One signed 7x7 multiplier shared round-robin by N_REQ requesters; result 2 edges after accept.
// Backpressure: a stalled result stage fills S1, then all req_rdy drop; nothing is lost or reordered.
module case_1_mul_share_arb #(
  parameter int N_REQ  = 4,
  parameter int DIN0_W = 7,
  parameter int DIN1_W = 7,
  parameter int DOUT_W = 11,
  parameter int TAG_W  = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  case_1_mul_share_arb_if.slave bus
);
  import case_1_mul_pkg::*;

  localparam int PROD_W = DIN0_W + DIN1_W;

  s1_t               s1_q;
  s2_t               s2_q;
  logic              s1_vld, s2_vld;
  logic [TAG_W-1:0]  ptr, gnt_idx, s2_tag;
  logic [N_REQ-1:0]  gnt_oh;
  logic              any;
  logic              s2_fire, s2_load, s1_adv, s1_load, acc;
  logic [DIN0_W-1:0] din0_sel;
  logic [DIN1_W-1:0] din1_sel;
  logic signed [PROD_W-1:0] op0, op1, prod;
  logic              ovf;
  logic              tag_unused;

  case_1_mul_rr_pick #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_pick (
    .req     (bus.req_vld),
    .ptr     (ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign s2_tag     = s2_q.tag[TAG_W-1:0];
  assign tag_unused = |(s2_q.tag >> TAG_W);

  // Only the owner of the S2 entry can retire it.
  assign s2_fire = s2_vld & bus.rsp_rdy[s2_tag];
  assign s2_load = ~s2_vld | s2_fire;
  assign s1_adv  = s1_vld & s2_load;
  assign s1_load = ~s1_vld | s1_adv;
  assign acc     = any & s1_load & ~ap_rst;

  assign bus.req_rdy = acc ? gnt_oh : '0;
  assign din0_sel    = bus.req_din0[int'(gnt_idx)*DIN0_W +: DIN0_W];
  assign din1_sel    = bus.req_din1[int'(gnt_idx)*DIN1_W +: DIN1_W];

  assign op0  = PROD_W'($signed(s1_q.din0));
  assign op1  = PROD_W'($signed(s1_q.din1));
  assign prod = op0 * op1;
  // Fits when every bit above the result sign bit matches it.
  assign ovf  = prod[PROD_W-1:DOUT_W-1] != {(PROD_W - DOUT_W + 1){prod[DOUT_W-1]}};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
      s2_vld <= 1'b0;
      s2_q   <= '0;
      ptr    <= '0;
    end else begin
      if (acc) begin
        s1_vld <= 1'b1;
        s1_q   <= '{din0: din0_sel, din1: din1_sel, tag: TAG_MAX_W'(gnt_idx)};
        ptr    <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
      if (s1_adv) begin
        s2_vld <= 1'b1;
        s2_q   <= '{dout: prod[DOUT_W-1:0], ovf: ovf, tag: s1_q.tag};
      end else if (s2_fire) begin
        s2_vld <= 1'b0;
      end
    end
  end

  assign bus.rsp_vld  = s2_vld ? (N_REQ'(1) << s2_tag) : '0;
  assign bus.rsp_dout = s2_q.dout;
  assign bus.rsp_ovf  = s2_q.ovf;
  assign bus.busy     = s1_vld | s2_vld;

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Scoreboard bench for the shared multiplier: directed grant/stall/reset cases then random stress.
module tb_case_1_mul_share_arb;

  localparam int N = 4;

  typedef struct {
    int          tag;
    logic [10:0] dout;
    logic        ovf;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  case_1_mul_share_arb_if #(.N_REQ(N), .DIN0_W(7), .DIN1_W(7), .DOUT_W(11)) bus ();

  case_1_mul_share_arb #(.N_REQ(N)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  exp_t              sbq[$];
  int                checks = 0;
  int                errors = 0;
  logic signed [6:0] a_q[N];
  logic signed [6:0] b_q[N];
  logic [N-1:0]      vld_q = '0;
  logic [N-1:0]      acc   = '0;
  int                accepted[N];
  int                retired[N];
  int                wait_cnt[N];
  int                max_wait = 0;
  bit                fair_on  = 1'b0;
  int                total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int tag, input logic signed [6:0] a, input logic signed [6:0] b);
    exp_t e;
    int   p;
    p      = int'(a) * int'(b);
    e.tag  = tag;
    e.dout = p[10:0];
    e.ovf  = (p > 1023) || (p < -1024);
    return e;
  endfunction

  task automatic new_data(input int i);
    a_q[i] = 7'($urandom);
    b_q[i] = 7'($urandom);
  endtask

  task automatic settle();
    bus.req_vld = vld_q;
    for (int i = 0; i < N; i++) begin
      bus.req_din0[i*7 +: 7] = a_q[i];
      bus.req_din1[i*7 +: 7] = b_q[i];
    end
    #1;
  endtask

  // Record transfers that the coming edge will perform, then advance to the next negedge.
  task automatic finish_cycle();
    exp_t e;
    acc = bus.req_vld & bus.req_rdy;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        sbq.push_back(model(i, a_q[i], b_q[i]));
        accepted[i]++;
      end
      if (fair_on) begin
        if (acc[i]) begin
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          wait_cnt[i] = 0;
        end else if (vld_q[i] && acc != '0) begin
          wait_cnt[i]++;
        end
      end
    end
    if (bus.rsp_vld != '0) begin
      chk("rsp_onehot", 32'($onehot(bus.rsp_vld)), 1);
      for (int t = 0; t < N; t++) begin
        if (bus.rsp_vld[t] && bus.rsp_rdy[t]) begin
          if (sbq.size() == 0) begin
            chk("sb_nonempty", sbq.size(), 1);
          end else begin
            e = sbq.pop_front();
            chk("rsp_tag", t, e.tag);
            chk("rsp_dout", bus.rsp_dout, e.dout);
            chk("rsp_ovf", bus.rsp_ovf, e.ovf);
            retired[t]++;
          end
        end
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic stream_refresh();
    for (int i = 0; i < N; i++) if (acc[i]) new_data(i);
  endtask

  task automatic drain();
    bus.rsp_rdy = '1;
    for (int k = 0; k < 64; k++) begin
      if (vld_q == '0 && !bus.busy) break;
      settle();
      finish_cycle();
      vld_q &= ~acc;
    end
    chk("drain_busy", bus.busy, 0);
    chk("drain_sb", sbq.size(), 0);
  endtask

  task automatic rst_pulse();
    ap_rst = 1'b1;
    #2;
    sbq.delete();
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_q[i] = 7'sd1;
      b_q[i] = 7'sd1;
      accepted[i] = 0;
      retired[i]  = 0;
      wait_cnt[i] = 0;
    end
    vld_q       = '1;
    bus.rsp_rdy = '1;
    settle();
    #2;
    chk("rst_req_rdy", bus.req_rdy, 0);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout", bus.rsp_dout, 0);
    chk("rst_ovf", bus.rsp_ovf, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    vld_q  = '0;

    // Single multiply: 5 * -3
    vld_q[0] = 1'b1; a_q[0] = 7'sd5; b_q[0] = -7'sd3;
    settle();
    chk("t1_req_rdy", bus.req_rdy, 4'b0001);
    finish_cycle();
    vld_q &= ~acc;
    settle();
    chk("t1_s1_rsp_vld", bus.rsp_vld, 0);
    chk("t1_s1_busy", bus.busy, 1);
    finish_cycle();
    settle();
    chk("t1_rsp_vld", bus.rsp_vld, 4'b0001);
    chk("t1_dout", bus.rsp_dout, 11'h7F1);
    chk("t1_ovf", bus.rsp_ovf, 0);
    finish_cycle();
    settle();
    chk("t1_idle", bus.busy, 0);
    finish_cycle();

    // Overflow corners; pointer sits at 1 after the first grant
    vld_q = 4'b0110;
    a_q[1] = 7'sd63;  b_q[1] = 7'sd63;
    a_q[2] = -7'sd64; b_q[2] = -7'sd64;
    settle();
    chk("t2_gnt1", bus.req_rdy, 4'b0010);
    finish_cycle();
    vld_q &= ~acc;
    settle();
    chk("t2_gnt2", bus.req_rdy, 4'b0100);
    finish_cycle();
    vld_q &= ~acc;
    settle();
    chk("t2_rsp1_vld", bus.rsp_vld, 4'b0010);
    chk("t2_rsp1_dout", bus.rsp_dout, 11'h781);
    chk("t2_rsp1_ovf", bus.rsp_ovf, 1);
    finish_cycle();
    settle();
    chk("t2_rsp2_vld", bus.rsp_vld, 4'b0100);
    chk("t2_rsp2_dout", bus.rsp_dout, 0);
    chk("t2_rsp2_ovf", bus.rsp_ovf, 1);
    finish_cycle();
    drain();

    // All requesters valid: strict rotation from pointer 0, one result per cycle
    rst_pulse();
    vld_q = '1;
    for (int i = 0; i < N; i++) new_data(i);
    for (int n = 0; n < 8; n++) begin
      settle();
      chk("t3_gnt", bus.req_rdy, 32'(1) << (n % N));
      if (n >= 2) chk("t3_rsp_vld", bus.rsp_vld, 32'(1) << ((n - 2) % N));
      finish_cycle();
      stream_refresh();
    end
    vld_q = '0;
    drain();

    // Result stall on tag 0; rsp_rdy[1] must not retire it
    bus.rsp_rdy = 4'b1110;
    vld_q = 4'b0011;
    new_data(0);
    new_data(1);
    settle();
    chk("t4_gnt0", bus.req_rdy, 4'b0001);
    finish_cycle();
    stream_refresh();
    settle();
    chk("t4_gnt1", bus.req_rdy, 4'b0010);
    finish_cycle();
    stream_refresh();
    for (int n = 0; n < 3; n++) begin
      settle();
      chk("t4_stall_rdy", bus.req_rdy, 0);
      chk("t4_stall_vld", bus.rsp_vld, 4'b0001);
      chk("t4_stall_busy", bus.busy, 1);
      chk("t4_stall_dout", bus.rsp_dout, sbq[0].dout);
      finish_cycle();
    end
    drain();

    // Asynchronous reset with both stages full
    bus.rsp_rdy = '0;
    vld_q = 4'b0011;
    new_data(0);
    new_data(1);
    for (int n = 0; n < 2; n++) begin
      settle();
      finish_cycle();
      stream_refresh();
    end
    settle();
    chk("t5_full_rdy", bus.req_rdy, 0);
    ap_rst = 1'b1;
    #1;
    chk("t5_rst_rsp_vld", bus.rsp_vld, 0);
    chk("t5_rst_req_rdy", bus.req_rdy, 0);
    chk("t5_rst_busy", bus.busy, 0);
    sbq.delete();
    vld_q = 4'b1001;
    new_data(0);
    new_data(3);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    bus.rsp_rdy = '1;
    settle();
    chk("t5_first_gnt", bus.req_rdy, 4'b0001);
    finish_cycle();
    vld_q &= ~acc;
    drain();

    // Random stress
    for (int i = 0; i < N; i++) begin
      accepted[i] = 0;
      retired[i]  = 0;
      wait_cnt[i] = 0;
    end
    fair_on = 1'b1;
    total   = 0;
    for (int cyc = 0; cyc < 60000 && total < 10000; cyc++) begin
      for (int i = 0; i < N; i++) bus.rsp_rdy[i] = ($urandom_range(0, 3) != 0);
      settle();
      finish_cycle();
      total += $countones(acc);
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !vld_q[i]) begin
          vld_q[i] = ($urandom_range(0, 3) != 0);
          new_data(i);
        end
      end
    end
    fair_on = 1'b0;
    chk("stress_count", 32'(total >= 10000), 1);
    drain();
    for (int i = 0; i < N; i++) chk("stress_tag_balance", retired[i], accepted[i]);
    chk("stress_fair", 32'(max_wait <= N), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
